vram_write_scheduler: RTL and testbench

VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

---
 rtl/vram_write_scheduler_pkg.sv | 33 +++
 rtl/vram_write_scheduler_if.sv | 40 ++++
 rtl/vram_write_fifo.sv | 54 +++++
 rtl/vram_write_scheduler.sv | 164 ++++++++++++++++
 tb/tb_vram_write_scheduler.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_write_scheduler_pkg.sv
// Shared definitions for the VRAM write scheduler: default sizes, fill states,
// and the round-robin arbitration helper.
package vram_write_scheduler_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_COLOR_WIDTH = 3;
    localparam int DEFAULT_FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

    typedef enum logic {
        OWNER_CPU  = 1'b0,
        OWNER_FILL = 1'b1
    } owner_t;

    // On contention the requester that did not win last time takes the port.
    function automatic owner_t rr_pick(input logic cpu_req, input logic fill_req,
                                       input owner_t last_owner);
        owner_t pick;
        if (cpu_req && fill_req)
            pick = (last_owner == OWNER_CPU) ? OWNER_FILL : OWNER_CPU;
        else if (cpu_req)
            pick = OWNER_CPU;
        else
            pick = OWNER_FILL;
        return pick;
    endfunction

endpackage

// File: rtl/vram_write_scheduler_if.sv
// Bus bundle for the scheduler: CPU pixel writes, fill control and the video
// memory write port. The DUT sits on the slave side.
interface vram_write_scheduler_if
    import vram_write_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int COLOR_WIDTH = DEFAULT_COLOR_WIDTH
);
    logic                   cpu_write;
    logic [ADDR_WIDTH-1:0]  cpu_address;
    logic [COLOR_WIDTH-1:0] cpu_color;
    logic                   cpu_full;
    logic                   cpu_overflow;

    logic                   fill_start;
    logic [ADDR_WIDTH-1:0]  fill_base;
    logic [ADDR_WIDTH-1:0]  fill_count;
    logic [COLOR_WIDTH-1:0] fill_color;
    logic                   fill_busy;
    logic                   fill_done;

    logic                   write_enable;
    logic [ADDR_WIDTH-1:0]  write_address;
    logic [COLOR_WIDTH-1:0] write_data;

    modport master (
        output cpu_write, cpu_address, cpu_color,
        output fill_start, fill_base, fill_count, fill_color,
        input  cpu_full, cpu_overflow, fill_busy, fill_done,
        input  write_enable, write_address, write_data
    );

    modport slave (
        input  cpu_write, cpu_address, cpu_color,
        input  fill_start, fill_base, fill_count, fill_color,
        output cpu_full, cpu_overflow, fill_busy, fill_done,
        output write_enable, write_address, write_data
    );

endinterface

// File: rtl/vram_write_fifo.sv
// CPU write buffer: power-of-two depth circular FIFO with show-ahead read data.
// Push when full and pop when empty are ignored.
module vram_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_scheduler.sv
// Merges buffered CPU pixel writes and a rectangular-span fill engine onto one
// registered video memory write port with round-robin arbitration.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FILL_IDLE | waiting for fill_start
//   FILL_RUN  | requesting the port; one pixel per granted cycle
//   FILL_DONE | fill finished; fill_done pulses in the following cycle
module vram_write_scheduler
    import vram_write_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int COLOR_WIDTH = DEFAULT_COLOR_WIDTH,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    vram_write_scheduler_if.slave bus
);
    localparam int ENTRY_W = ADDR_WIDTH + COLOR_WIDTH;

    fill_state_t            state;
    fill_state_t            state_next;
    logic                   load_fill;
    logic                   step_fill;
    logic [ADDR_WIDTH-1:0]  fill_addr;
    logic [ADDR_WIDTH-1:0]  fill_remaining;
    logic [COLOR_WIDTH-1:0] fill_color_q;
    logic                   fill_done_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic [ENTRY_W-1:0]     fifo_rd_data;
    logic                   overflow_q;

    logic                   cpu_req;
    logic                   fill_req;
    owner_t                 winner;
    owner_t                 last_owner;
    logic                   grant_cpu;
    logic                   grant_fill;

    logic                   write_enable_q;
    logic [ADDR_WIDTH-1:0]  write_address_q;
    logic [COLOR_WIDTH-1:0] write_data_q;

    // A write arriving while full is dropped even if a pop frees a slot this cycle.
    assign fifo_push = bus.cpu_write && !fifo_full;

    vram_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (grant_cpu),
        .wr_data ({bus.cpu_address, bus.cpu_color}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .rd_data (fifo_rd_data)
    );

    assign cpu_req    = !fifo_empty;
    assign fill_req   = (state == FILL_RUN);
    assign winner     = rr_pick(cpu_req, fill_req, last_owner);
    assign grant_cpu  = cpu_req && (winner == OWNER_CPU);
    assign grant_fill = fill_req && (winner == OWNER_FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FILL_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_fill  = 1'b0;
        step_fill  = 1'b0;
        case (state)
            FILL_IDLE: begin
                if (bus.fill_start) begin
                    if (bus.fill_count != '0) begin
                        state_next = FILL_RUN;
                        load_fill  = 1'b1;
                    end else begin
                        state_next = FILL_DONE;
                    end
                end
            end
            FILL_RUN: begin
                if (grant_fill) begin
                    step_fill = 1'b1;
                    if (fill_remaining == ADDR_WIDTH'(1))
                        state_next = FILL_DONE;
                end
            end
            FILL_DONE: state_next = FILL_IDLE;
            default:   state_next = FILL_IDLE;
        endcase
    end

    // Remaining pixels count down to the terminal value of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_addr      <= '0;
            fill_remaining <= '0;
            fill_color_q   <= '0;
            fill_done_q    <= 1'b0;
        end else begin
            if (load_fill) begin
                fill_addr      <= bus.fill_base;
                fill_remaining <= bus.fill_count;
                fill_color_q   <= bus.fill_color;
            end else if (step_fill) begin
                fill_addr      <= fill_addr + 1'b1;
                fill_remaining <= fill_remaining - 1'b1;
            end
            fill_done_q <= (state == FILL_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWNER_FILL;
            overflow_q <= 1'b0;
        end else begin
            if (grant_cpu)
                last_owner <= OWNER_CPU;
            else if (grant_fill)
                last_owner <= OWNER_FILL;
            if (bus.cpu_write && fifo_full)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            write_enable_q <= grant_cpu || grant_fill;
            if (grant_cpu) begin
                write_address_q <= fifo_rd_data[ENTRY_W-1:COLOR_WIDTH];
                write_data_q    <= fifo_rd_data[COLOR_WIDTH-1:0];
            end else if (grant_fill) begin
                write_address_q <= fill_addr;
                write_data_q    <= fill_color_q;
            end
        end
    end

    assign bus.cpu_full      = fifo_full;
    assign bus.cpu_overflow  = overflow_q;
    assign bus.fill_busy     = (state != FILL_IDLE);
    assign bus.fill_done     = fill_done_q;
    assign bus.write_enable  = write_enable_q;
    assign bus.write_address = write_address_q;
    assign bus.write_data    = write_data_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: every write-port event and fill_done
// pulse is logged with its cycle number and compared against hand-built tables.
module tb_vram_write_scheduler;
    import vram_write_scheduler_pkg::*;

    localparam int AW = 16;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_write_scheduler_if #(.ADDR_WIDTH(AW), .COLOR_WIDTH(CW)) bus();

    vram_write_scheduler #(
        .ADDR_WIDTH  (AW),
        .COLOR_WIDTH (CW),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [2:0]  data;
    } wr_t;

    wr_t wr_log[$];
    int  done_log[$];
    int  cyc = 0;
    int  n_compared = 0;
    int  n_mismatched = 0;

    always @(negedge clk) begin
        if (bus.write_enable)
            wr_log.push_back('{cyc, bus.write_address, bus.write_data});
        if (bus.fill_done)
            done_log.push_back(cyc);
        cyc++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input int exp_cyc,
                               input logic [15:0] exp_addr, input logic [2:0] exp_data);
        if (idx < wr_log.size()) begin
            check_val($sformatf("%s[%0d].cyc", tag, idx), 32'(wr_log[idx].cyc), 32'(exp_cyc));
            check_val($sformatf("%s[%0d].addr", tag, idx), 32'(wr_log[idx].addr), 32'(exp_addr));
            check_val($sformatf("%s[%0d].data", tag, idx), 32'(wr_log[idx].data), 32'(exp_data));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cpu_write   = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_color   = '0;
        bus.fill_start  = 1'b0;
        bus.fill_base   = '0;
        bus.fill_count  = '0;
        bus.fill_color  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        wr_log.delete();
        done_log.delete();
    endtask

    task automatic start_fill(input logic [15:0] base, input logic [15:0] count,
                              input logic [2:0] color);
        bus.fill_start = 1'b1;
        bus.fill_base  = base;
        bus.fill_count = count;
        bus.fill_color = color;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [15:0] wrap_addr [4];
        logic [15:0] mix_addr  [13];
        logic [2:0]  mix_data  [13];

        // Reset values
        clear_inputs();
        rst = 1'b1;
        repeat (2) tick();
        check_val("rst.write_enable",  32'(bus.write_enable), 32'h0);
        check_val("rst.write_address", 32'(bus.write_address), 32'h0);
        check_val("rst.write_data",    32'(bus.write_data), 32'h0);
        check_val("rst.cpu_full",      32'(bus.cpu_full), 32'h0);
        check_val("rst.cpu_overflow",  32'(bus.cpu_overflow), 32'h0);
        check_val("rst.fill_busy",     32'(bus.fill_busy), 32'h0);
        check_val("rst.fill_done",     32'(bus.fill_done), 32'h0);
        rst = 1'b0;
        tick();
        wr_log.delete();
        done_log.delete();

        // Single CPU write lands two cycles after the push
        n0 = cyc;
        bus.cpu_write   = 1'b1;
        bus.cpu_address = 16'h0102;
        bus.cpu_color   = 3'b101;
        tick();
        bus.cpu_write = 1'b0;
        repeat (6) tick();
        check_val("single.count", 32'(wr_log.size()), 32'd1);
        check_write("single", 0, n0 + 2, 16'h0102, 3'b101);

        // Five back-to-back CPU writes drain one per cycle, nothing dropped
        do_reset();
        n0 = cyc;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_write   = 1'b1;
            bus.cpu_address = 16'h0010 + 16'(i);
            bus.cpu_color   = 3'(i + 1);
            tick();
        end
        bus.cpu_write = 1'b0;
        repeat (6) tick();
        check_val("burst5.count", 32'(wr_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check_write("burst5", i, n0 + 2 + i, 16'h0010 + 16'(i), 3'(i + 1));
        check_val("burst5.overflow", 32'(bus.cpu_overflow), 32'h0);
        check_val("burst5.full", 32'(bus.cpu_full), 32'h0);

        // Fill wrapping past the top of the address space
        do_reset();
        wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        n0 = cyc;
        start_fill(16'hFFFE, 16'd4, 3'b010);
        tick();
        bus.fill_start = 1'b0;
        check_val("wrap.busy_run", 32'(bus.fill_busy), 32'h1);
        repeat (8) tick();
        check_val("wrap.count", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_write("wrap", i, n0 + 2 + i, wrap_addr[i], 3'b010);
        check_val("wrap.done_pulses", 32'(done_log.size()), 32'd1);
        if (done_log.size() > 0)
            check_val("wrap.done_cyc", 32'(done_log[0]), 32'(n0 + 6));
        check_val("wrap.busy_idle", 32'(bus.fill_busy), 32'h0);

        // Contention: CPU wins first, then strict alternation; 8th CPU write dropped
        do_reset();
        mix_addr = '{16'h1000, 16'h0200, 16'h1001, 16'h0201, 16'h1002, 16'h0202, 16'h1003,
                     16'h0203, 16'h1004, 16'h0204, 16'h1005, 16'h0205, 16'h1006};
        mix_data = '{3'b111, 3'b010, 3'b111, 3'b010, 3'b111, 3'b010, 3'b111,
                     3'b010, 3'b111, 3'b010, 3'b111, 3'b010, 3'b111};
        n0 = cyc;
        for (int i = 0; i < 8; i++) begin
            if (i == 7)
                check_val("mix.full_before_drop", 32'(bus.cpu_full), 32'h1);
            if (i == 0)
                start_fill(16'h0200, 16'd6, 3'b010);
            bus.cpu_write   = 1'b1;
            bus.cpu_address = 16'h1000 + 16'(i);
            bus.cpu_color   = 3'b111;
            tick();
            bus.fill_start = 1'b0;
        end
        bus.cpu_write = 1'b0;
        repeat (12) tick();
        check_val("mix.count", 32'(wr_log.size()), 32'd13);
        for (int i = 0; i < 13; i++)
            check_write("mix", i, n0 + 2 + i, mix_addr[i], mix_data[i]);
        check_val("mix.overflow", 32'(bus.cpu_overflow), 32'h1);
        check_val("mix.done_pulses", 32'(done_log.size()), 32'd1);
        if (done_log.size() > 0)
            check_val("mix.done_cyc", 32'(done_log[0]), 32'(n0 + 14));

        // Zero-length fill: no writes, done two cycles after the start strobe
        do_reset();
        n0 = cyc;
        start_fill(16'h0700, 16'd0, 3'b011);
        tick();
        bus.fill_start = 1'b0;
        check_val("zero.busy", 32'(bus.fill_busy), 32'h1);
        repeat (4) tick();
        check_val("zero.count", 32'(wr_log.size()), 32'd0);
        check_val("zero.done_pulses", 32'(done_log.size()), 32'd1);
        if (done_log.size() > 0)
            check_val("zero.done_cyc", 32'(done_log[0]), 32'(n0 + 2));

        // Start strobe during RUN is ignored
        wr_log.delete();
        done_log.delete();
        n0 = cyc;
        start_fill(16'h0300, 16'd3, 3'b101);
        tick();
        bus.fill_start = 1'b0;
        tick();
        start_fill(16'h0500, 16'd5, 3'b001);
        tick();
        bus.fill_start = 1'b0;
        repeat (8) tick();
        check_val("restart.count", 32'(wr_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check_write("restart", i, n0 + 2 + i, 16'h0300 + 16'(i), 3'b101);
        check_val("restart.done_pulses", 32'(done_log.size()), 32'd1);
        if (done_log.size() > 0)
            check_val("restart.done_cyc", 32'(done_log[0]), 32'(n0 + 5));

        // Reset in the middle of an 8-pixel fill
        do_reset();
        n0 = cyc;
        start_fill(16'h0400, 16'd8, 3'b110);
        tick();
        bus.fill_start = 1'b0;
        repeat (2) tick();
        check_val("abort.we_before", 32'(bus.write_enable), 32'h1);
        check_val("abort.addr_before", 32'(bus.write_address), 32'h0401);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("abort.we_cleared", 32'(bus.write_enable), 32'h0);
        check_val("abort.addr_cleared", 32'(bus.write_address), 32'h0);
        check_val("abort.data_cleared", 32'(bus.write_data), 32'h0);
        check_val("abort.busy_cleared", 32'(bus.fill_busy), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check_val("abort.count", 32'(wr_log.size()), 32'd2);
        for (int i = 0; i < 2; i++)
            check_write("abort", i, n0 + 2 + i, 16'h0400 + 16'(i), 3'b110);
        check_val("abort.done_pulses", 32'(done_log.size()), 32'd0);
        check_val("abort.busy_after", 32'(bus.fill_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
